// File: rtl/flasher_pkg.sv
// flasher_pkg
// Shared types and constants for the bound-flasher flick scheduler.
//   sched_state_t : scheduler FSM states
//   FL_IDLE       : flasher state-register value meaning "idle"
//   KB_LO / KB_HI : lamp patterns at which a kickback flick is allowed
//   LAMPS_W       : width of the flasher lamp vector
package flasher_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLICK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  localparam logic [2:0]  FL_IDLE = 3'd0;
  localparam int          LAMPS_W = 16;
  localparam logic [15:0] KB_LO   = 16'h003F;
  localparam logic [15:0] KB_HI   = 16'h07FF;

endpackage

// File: rtl/flasher_flick_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Priority starts at the index after ptr.
//   req : request vector
//   ptr : index of the last grantee
//   win : one-hot winner (all zero when no request)
//   any : at least one request present
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         win,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   start;
  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;

  // Rotate so the first eligible index lands at bit 0, take the lowest set
  // bit, then rotate the one-hot result back into requester order.
  always_comb begin
    start = (ptr == PW'(NREQ - 1)) ? '0 : ptr + 1'b1;
    rot   = NREQ'({req, req} >> start);
    pick  = rot & (~rot + 1'b1);
    win   = NREQ'({pick, pick} << start >> NREQ);
    any   = |req;
  end

endmodule

// File: rtl/flasher_flick_sched.sv
// flasher_flick_sched
// Shares one bound-flasher among NREQ requesters. Grants one requester at a
// time, drives the flasher's flick input to start a run, watches fl_state
// until the run ends and returns a one-cycle done pulse to the owner.
// Ports:
//   clk, rst (synchronous, active-low)
//   req[NREQ]  : level requests, held until done
//   kick[NREQ] : kickback requests (only with FLASHER_KICKBACK_EN)
//   fl_state   : flasher state register, lamps : flasher lamp vector
//   flick      : flasher flick input
//   grant      : one-hot current owner, done : completion pulse to owner
//   err        : one-cycle timeout pulse, busy : scheduler not idle
// Optional feature: define FLASHER_KICKBACK_EN to let the owner re-flick the
// flasher during RUN when the lamps sit at KB_LO or KB_HI.
module flasher_flick_sched
  import flasher_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int START_TO = 16,
  parameter int RUN_TO   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    kick,
  input  logic [2:0]         fl_state,
  input  logic [LAMPS_W-1:0] lamps,
  output logic               flick,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               err,
  output logic               busy
);

  localparam int CW = $clog2((START_TO > RUN_TO) ? START_TO : RUN_TO);
  localparam int PW = $clog2(NREQ);

  sched_state_t    state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic            flick_reg, flick_next;
  logic            err_reg, err_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic [NREQ-1:0] win;
  logic            any_req;
  logic [PW-1:0]   owner_idx;
  logic [CW-1:0]   cnt_inc;
  logic            fl_active;
  logic            start_expired;
  logic            run_expired;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .win (win),
    .any (any_req)
  );

  assign fl_active     = (fl_state != FL_IDLE);
  assign start_expired = (cnt_reg == CW'(START_TO - 1));
  assign run_expired   = (cnt_reg == CW'(RUN_TO - 1));
  // Saturating increment: the counter must never wrap back to zero.
  assign cnt_inc       = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_reg[i]) owner_idx = PW'(i);
    end
  end

  // State register (plus the registered outputs and datapath).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      grant_reg <= '0;
      done_reg  <= '0;
      flick_reg <= 1'b0;
      err_reg   <= 1'b0;
      ptr_reg   <= PW'(NREQ - 1);   // req[0] wins the first arbitration
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
      flick_reg <= flick_next;
      err_reg   <= err_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_req) state_next = S_FLICK;
      S_FLICK: begin
        if (fl_active)          state_next = S_RUN;
        else if (start_expired) state_next = S_IDLE;
      end
      S_RUN: begin
        if (!fl_active)       state_next = S_DONE;
        else if (run_expired) state_next = S_IDLE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    grant_next = grant_reg;
    done_next  = '0;
    flick_next = flick_reg;
    err_next   = 1'b0;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_inc;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (any_req) begin
          grant_next = win;
          flick_next = 1'b1;
        end
      end
      S_FLICK: begin
        if (fl_active) begin
          flick_next = 1'b0;
          cnt_next   = '0;
        end else if (start_expired) begin
          err_next   = 1'b1;
          grant_next = '0;
          flick_next = 1'b0;
          ptr_next   = owner_idx;
        end
      end
      S_RUN: begin
        // done is raised on entry to DONE so it is visible during DONE.
        if (!fl_active) begin
          done_next = grant_reg;
        end else if (run_expired) begin
          err_next   = 1'b1;
          grant_next = '0;
          ptr_next   = owner_idx;
        end
      end
      S_DONE: begin
        grant_next = '0;
        ptr_next   = owner_idx;
        cnt_next   = '0;
      end
      default: begin
        grant_next = '0;
        flick_next = 1'b0;
      end
    endcase
  end

  assign grant = grant_reg;
  assign done  = done_reg;
  assign err   = err_reg;
  assign busy  = (state_reg != S_IDLE);

`ifdef FLASHER_KICKBACK_EN
  // Combinational so the Mealy flasher sees the flick in the same cycle the
  // lamps reach a kickback pattern.
  logic kb_hit;
  assign kb_hit = (state_reg == S_RUN) && (|(kick & grant_reg)) &&
                  ((lamps == KB_LO) || (lamps == KB_HI));
  assign flick  = flick_reg | kb_hit;
`else
  logic unused_inputs;
  assign unused_inputs = ^{kick, lamps};
  assign flick         = flick_reg;
`endif

endmodule

// File: doc/flasher_flick_sched.md
# flasher_flick_sched

Round-robin scheduler that shares one bound-flasher instance between several requesters. It grants one requester at a time and drives the flasher's `flick` input to start a run. It then watches the flasher's state and lamps until the run ends, and returns a per-requester `done` pulse. It sits directly in front of the flasher and owns that flasher's `flick` input exclusively.

## Interface
- `NREQ`, 3, number of requesters (2..8)
- `START_TO`, 16, maximum FLICK-state cycles before the flasher must leave its idle state
- `RUN_TO`, 4096, maximum RUN-state cycles before the run is declared hung
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `req`  in  NREQ  level request per requester; held until its `done`
- `kick`  in  NREQ  kickback request per requester (used only with `FLASHER_KICKBACK_EN`)
- `fl_state`  in  3  flasher state register
- `lamps`  in  16  flasher lamp vector
- `flick`  out  1  flasher flick input
- `grant`  out  NREQ  one-hot current owner
- `done`  out  NREQ  one-cycle completion pulse to the owner
- `err`  out  1  one-cycle timeout pulse
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, FLICK, RUN, DONE.
- **IDLE**
  - If `req` is non-zero, pick the winner round-robin, starting at the index after the last grantee.
  - Next cycle: state = FLICK, `grant` = winner one-hot, `flick_r` = 1, cycle counter cleared.
- **FLICK**
  - `flick_r` stays 1.
  - If `fl_state` != FL_IDLE (0): go to RUN with `flick_r` = 0 and counter cleared.
  - Else if counter == START_TO-1: pulse `err`, clear `grant`, go to IDLE.
- **RUN**
  - If `fl_state` == FL_IDLE: go to DONE.
  - Else if counter == RUN_TO-1: pulse `err`, clear `grant`, go to IDLE.
- **DONE**
  - `done[g]` = 1 for one cycle, `grant` cleared, go to IDLE.
- After any termination (DONE or a timeout), the round-robin pointer = index of the grantee.
- The grantee dropping `req` mid-run is ignored. The run completes and `done` still pulses.
- `req` from non-grantees is ignored until IDLE.
- A requester still holding `req` after its `done` is re-arbitrated normally. Round-robin keeps it from starving the others.
- Counter width is `$clog2(max(START_TO, RUN_TO))`. The counter saturates and never wraps.
- `err` and `done` are never high in the same cycle.

## Timing
- Reset values (rst = 0 at an edge): state IDLE, `flick` 0, `grant` 0, `done` 0, `err` 0, `busy` 0.
- Round-robin pointer resets to NREQ-1, so `req[0]` wins first.
- Reset mid-operation aborts with no `done` and no `err`.
- `req` rises at edge N: `grant` and `flick` rise at edge N+1.
- `fl_state` leaves 0 and is sampled at edge M: `flick` falls at edge M+1.
- `fl_state` returns to 0 and is sampled at edge K: `done` is high in cycle K+1, and the scheduler is in IDLE at K+2.
- Minimum back-to-back gap is one IDLE cycle between `done` and the next `grant`.
- Simultaneous requests in IDLE: exactly one grant, no multi-hot `grant`.

## Configuration
- Macro: `FLASHER_KICKBACK_EN`.
- **Defined**
  - In RUN, `flick` = `kick[g]` && (`lamps` == KB_LO 16'h003F || `lamps` == KB_HI 16'h07FF).
  - This term is combinational from `lamps`, so the Mealy flasher sees it in the same cycle.
  - `kick` is ignored outside RUN and for non-grantees.
- **Not defined**
  - The `kick` port is present but unused.
  - `flick` is purely registered (`flick_r`) and is 0 throughout RUN.

## Structure
- `flasher_pkg` holds:
  - the scheduler state enum
  - `FL_IDLE` = 3'd0
  - `KB_LO` = 16'h003F
  - `KB_HI` = 16'h07FF
  - `LAMPS_W` = 16
- Sub-module `rr_arbiter` (parameter NREQ):
  - inputs: `req`, `ptr`
  - outputs: one-hot `win`, `any`
  - purely combinational, with a rotate-and-priority implementation.
- FSM, counter and pointer live in the top module.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with `req` = 3'b111 → all outputs 0. After release, `grant` = 3'b001 one cycle later.
- **Single run:** `req` = 3'b010, with a flasher model leaving state 0 one cycle after `flick` and returning after 200 cycles → `flick` high exactly 2 cycles, `done` = 3'b010 for one cycle, `busy` falls the cycle after.
- **Round-robin:** `req` held at 3'b111 for three runs → grant order 001, 010, 100, then 001 again.
- **Start timeout:** model never leaves state 0 → `err` pulses at FLICK cycle 16, `grant` = 0, no `done`.
- **Kickback (`FLASHER_KICKBACK_EN`):** grantee holds `kick` = 1 → `flick` = 1 in exactly the cycles where `lamps` is 16'h003F or 16'h07FF. With `kick` = 0, `flick` stays 0 throughout RUN.
- **Reset mid-run:** `rst` = 0 during RUN → the next cycle shows IDLE with all outputs 0, and no `done` or `err` is emitted.
